// File: rtl/wide_mux_pipe.sv
// N_IN:1 wide multiplexer built from SLICE-bit lanes, followed by a two-stage valid/ready pipeline.
// Define WIDE_MUX_PIPE_PARITY_EN to add the registered even-parity output y_par.
module wide_mux_pipe #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned SLICE = 2,
   parameter  int unsigned N_IN  = 4,
   localparam int unsigned SW    = $clog2(N_IN)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_IN*WIDTH-1:0] din,
   input  logic [SW-1:0]         sel,
   input  logic                  scan,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      y,
   output logic [SW-1:0]         y_chan,
   output logic                  out_valid,
   input  logic                  out_ready
`ifdef WIDE_MUX_PIPE_PARITY_EN
   ,
   output logic                  y_par
`endif
);

   localparam int unsigned LANES = WIDTH / SLICE;

   if (WIDTH % SLICE != 0) begin : g_bad_slice
      $error("wide_mux_pipe: WIDTH must be a multiple of SLICE");
   end

   if (N_IN < 2) begin : g_bad_n_in
      $error("wide_mux_pipe: N_IN must be at least 2");
   end

   logic [SW-1:0]    cnt_q;
   logic [SW-1:0]    eff_sel;
   logic [WIDTH-1:0] mux_out;

   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_data_q;
   logic [SW-1:0]    s1_chan_q;

   logic             s2_valid_q;
   logic [WIDTH-1:0] s2_data_q;
   logic [SW-1:0]    s2_chan_q;

   logic             accept;
   logic             s2_load;

   // Out-of-range select values fall back to channel 0.
   always_comb begin
      if (scan) begin
         eff_sel = cnt_q;
      end else if (32'(sel) < N_IN) begin
         eff_sel = sel;
      end else begin
         eff_sel = '0;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [SLICE-1:0] lane;

      always_comb begin
         lane = '0;
         for (int c = 0; c < N_IN; c++) begin
            if (eff_sel == SW'(c)) begin
               lane = din[c*WIDTH + l*SLICE +: SLICE];
            end
         end
      end

      assign mux_out[l*SLICE +: SLICE] = lane;
   end

   assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
   // Held low during reset so nothing is accepted while the pipeline is being flushed.
   assign in_ready = !rst && (!s1_valid_q || s2_load);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_chan_q  <= '0;
      end else if (accept) begin
         s1_valid_q <= 1'b1;
         s1_data_q  <= mux_out;
         s1_chan_q  <= eff_sel;
      end else if (s2_load) begin
         s1_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_chan_q  <= '0;
      end else if (s2_load) begin
         s2_valid_q <= 1'b1;
         s2_data_q  <= s1_data_q;
         s2_chan_q  <= s1_chan_q;
      end else if (out_ready) begin
         s2_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (accept && scan) begin
         cnt_q <= (cnt_q == SW'(N_IN - 1)) ? '0 : cnt_q + 1'b1;
      end
   end

   assign y         = s2_data_q;
   assign y_chan    = s2_chan_q;
   assign out_valid = s2_valid_q;

`ifdef WIDE_MUX_PIPE_PARITY_EN
   logic s2_par_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_par_q <= 1'b0;
      end else if (s2_load) begin
         s2_par_q <= ^s1_data_q;
      end
   end

   assign y_par = s2_par_q;
`endif

endmodule

// File: tb/tb_wide_mux_pipe.sv
// Self-checking bench for wide_mux_pipe: a capacity-2, min-latency-1 FIFO model drives all expectations.
// A second instance with N_IN=5 covers out-of-range select values.
module tb_wide_mux_pipe;

   logic        clk;
   logic        rst;
   logic [31:0] din;
   logic [1:0]  sel;
   logic        scan;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  y;
   logic [1:0]  y_chan;
   logic        out_valid;
   logic        out_ready;

   logic [39:0] din_b;
   logic [2:0]  sel_b;
   logic        in_valid_b;
   logic        in_ready_b;
   logic [7:0]  y_b;
   logic [2:0]  y_chan_b;
   logic        out_valid_b;
   logic        out_ready_b;

`ifdef WIDE_MUX_PIPE_PARITY_EN
   logic        y_par;
   logic        y_par_b;
`endif

   int errors = 0;
   int checks = 0;

   wide_mux_pipe #(.WIDTH(8), .SLICE(2), .N_IN(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .sel       (sel),
      .scan      (scan),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y         (y),
      .y_chan    (y_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef WIDE_MUX_PIPE_PARITY_EN
      ,
      .y_par     (y_par)
`endif
   );

   wide_mux_pipe #(.WIDTH(8), .SLICE(2), .N_IN(5)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .din       (din_b),
      .sel       (sel_b),
      .scan      (1'b0),
      .in_valid  (in_valid_b),
      .in_ready  (in_ready_b),
      .y         (y_b),
      .y_chan    (y_chan_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready_b)
`ifdef WIDE_MUX_PIPE_PARITY_EN
      ,
      .y_par     (y_par_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: items in flight, oldest first; an item is visible one edge after acceptance.
   typedef struct {
      logic [7:0] d;
      logic [1:0] c;
      int         age;
   } item_t;

   item_t q[$];
   int    mcnt = 0;

   function automatic logic m_in_ready();
      if (rst) return 1'b0;
      return (q.size() < 2) || out_ready;
   endfunction

   function automatic logic m_out_valid();
      return (q.size() > 0) && (q[0].age >= 1);
   endfunction

   // Advance one clock: update the model with what happens at the coming edge, end at the next negedge.
   task automatic step();
      logic  acc;
      logic  pop;
      int    ch;
      item_t it;
      acc = in_valid && m_in_ready();
      pop = m_out_valid() && out_ready;
      if (scan) ch = mcnt;
      else      ch = int'(sel);
      it.d   = din[ch*8 +: 8];
      it.c   = 2'(ch);
      it.age = 0;
      @(posedge clk);
      if (rst) begin
         q.delete();
         mcnt = 0;
      end else begin
         if (pop) void'(q.pop_front());
         foreach (q[i]) q[i].age++;
         if (acc) begin
            q.push_back(it);
            if (scan) mcnt = (mcnt + 1) % 4;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++;
      if (y !== 8'h00) begin errors++; $display("FAIL rst_y: got %h want 00", y); end
      checks++;
      if (y_chan !== 2'd0) begin errors++; $display("FAIL rst_y_chan: got %0d want 0", y_chan); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
`ifdef WIDE_MUX_PIPE_PARITY_EN
      checks++;
      if (y_par !== 1'b0) begin errors++; $display("FAIL rst_y_par: got %b want 0", y_par); end
`endif
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_held: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
      end
      in_valid = 1'b0;
      rst      = 1'b0;
   endtask

   task automatic test_basic();
      din = {8'h44, 8'h33, 8'h22, 8'h11}; sel = 2'd2; scan = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
      step();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_s1_only: out_valid got %b want 0", out_valid); end
      step();
      #1;
      checks++;
      if (out_valid !== 1'b1 || y !== 8'h33 || y_chan !== 2'd2) begin
         errors++;
         $display("FAIL basic_out: got v=%b y=%h ch=%0d want v=1 y=33 ch=2", out_valid, y, y_chan);
      end
      step();
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_scan_back_to_back();
      int exp_ch[6] = '{0, 1, 2, 3, 0, 1};
      int nout = 0;
      scan = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         in_valid = (k < 6);
         din      = $urandom;
         #1;
         if (k < 6) begin
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL scan_in_ready[%0d]: got %b want 1", k, in_ready); end
         end
         checks++;
         if (out_valid !== m_out_valid()) begin
            errors++;
            $display("FAIL scan_out_valid[%0d]: got %b want %b", k, out_valid, m_out_valid());
         end
         if (m_out_valid() && nout < 6) begin
            checks++;
            if (y_chan !== 2'(exp_ch[nout]) || y !== q[0].d) begin
               errors++;
               $display("FAIL scan_seq[%0d]: got ch=%0d y=%h want ch=%0d y=%h", nout, y_chan, y, exp_ch[nout], q[0].d);
            end
            nout++;
         end
         step();
      end
      checks++;
      if (nout != 6) begin errors++; $display("FAIL scan_count: got %0d outputs want 6", nout); end
   endtask

   task automatic test_backpressure();
      int sels[3]   = '{1, 3, 0};
      int nacc      = 0;
      int nout      = 0;
      logic [7:0] ch_data[4];
      scan = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
      din  = $urandom;
      for (int i = 0; i < 4; i++) ch_data[i] = din[i*8 +: 8];
      for (int k = 0; k < 4; k++) begin
         sel = 2'(sels[nacc]);
         #1;
         checks++;
         if (in_ready !== m_in_ready()) begin
            errors++;
            $display("FAIL bp_in_ready[%0d]: got %b want %b", k, in_ready, m_in_ready());
         end
         if (m_in_ready()) nacc++;
         step();
      end
      #1;
      checks++;
      if (nacc != 2 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_stall: accepts=%0d in_ready=%b want 2 0", nacc, in_ready);
      end
      checks++;
      if (y !== ch_data[1] || y_chan !== 2'd1) begin
         errors++;
         $display("FAIL bp_hold: got y=%h ch=%0d want y=%h ch=1", y, y_chan, ch_data[1]);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_valid = (nacc < 3);
         if (nacc < 3) sel = 2'(sels[nacc]);
         #1;
         if (in_valid && m_in_ready()) nacc++;
         checks++;
         if (out_valid !== m_out_valid()) begin
            errors++;
            $display("FAIL bp_out_valid[%0d]: got %b want %b", k, out_valid, m_out_valid());
         end
         if (m_out_valid() && nout < 3) begin
            checks++;
            if (y_chan !== 2'(sels[nout]) || y !== ch_data[sels[nout]]) begin
               errors++;
               $display("FAIL bp_order[%0d]: got ch=%0d y=%h want ch=%0d y=%h",
                        nout, y_chan, y, sels[nout], ch_data[sels[nout]]);
            end
            nout++;
         end
         step();
      end
      checks++;
      if (nout != 3) begin errors++; $display("FAIL bp_count: got %0d outputs want 3", nout); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         if ($urandom_range(7) == 0) scan = ~scan;
         sel = 2'($urandom_range(3));
         din = $urandom;
         #1;
         checks++;
         if (in_ready !== m_in_ready()) begin
            errors++;
            $display("FAIL rand_in_ready[%0d]: got %b want %b", k, in_ready, m_in_ready());
         end
         checks++;
         if (out_valid !== m_out_valid()) begin
            errors++;
            $display("FAIL rand_out_valid[%0d]: got %b want %b", k, out_valid, m_out_valid());
         end
         if (m_out_valid()) begin
            checks++;
            if (y !== q[0].d || y_chan !== q[0].c) begin
               errors++;
               $display("FAIL rand_data[%0d]: got y=%h ch=%0d want y=%h ch=%0d", k, y, y_chan, q[0].d, q[0].c);
            end
`ifdef WIDE_MUX_PIPE_PARITY_EN
            checks++;
            if (y_par !== ^q[0].d) begin
               errors++;
               $display("FAIL rand_par[%0d]: got %b want %b", k, y_par, ^q[0].d);
            end
`endif
         end
         step();
      end
   endtask

   task automatic test_sel_range();
      int sels[5] = '{6, 4, 5, 7, 1};
      int exps[5] = '{0, 4, 0, 0, 1};
      logic [7:0] ch_data[5];
      out_ready_b = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ch_data[i] = 8'($urandom);
         din_b[i*8 +: 8] = ch_data[i];
      end
      for (int k = 0; k < 5; k++) begin
         sel_b = 3'(sels[k]); in_valid_b = 1'b1;
         #1;
         checks++;
         if (in_ready_b !== 1'b1) begin errors++; $display("FAIL selr_in_ready[%0d]: got %b want 1", k, in_ready_b); end
         @(posedge clk);
         @(negedge clk);
         in_valid_b = 1'b0;
         @(posedge clk);
         @(negedge clk);
         #1;
         checks++;
         if (out_valid_b !== 1'b1 || y_chan_b !== 3'(exps[k]) || y_b !== ch_data[exps[k]]) begin
            errors++;
            $display("FAIL selr_out[sel=%0d]: got v=%b ch=%0d y=%h want v=1 ch=%0d y=%h",
                     sels[k], out_valid_b, y_chan_b, y_b, exps[k], ch_data[exps[k]]);
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

`ifdef WIDE_MUX_PIPE_PARITY_EN
   task automatic test_parity();
      logic [7:0] vals[2] = '{8'h07, 8'h03};
      logic       exps[2] = '{1'b1, 1'b0};
      scan = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         din = {8'h00, vals[k], 8'h00, 8'h00}; sel = 2'd2; in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         step();
         #1;
         checks++;
         if (out_valid !== 1'b1 || y !== vals[k] || y_par !== exps[k]) begin
            errors++;
            $display("FAIL parity[%h]: got v=%b y=%h par=%b want v=1 y=%h par=%b",
                     vals[k], out_valid, y, y_par, vals[k], exps[k]);
         end
         step();
      end
   endtask
`endif

   task automatic test_async_reset();
      int guard = 0;
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) step();
      scan = 1'b1; in_valid = 1'b1;
      if (mcnt == 0) step();
      scan = 1'b0; out_ready = 1'b0; sel = 2'd3; din = $urandom;
      while (q.size() < 2 && guard < 4) begin
         step();
         guard++;
      end
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL arst_full: out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || y !== 8'h00 || y_chan !== 2'd0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL arst_immediate: got v=%b y=%h ch=%0d rdy=%b want 0 00 0 0", out_valid, y, y_chan, in_ready);
      end
`ifdef WIDE_MUX_PIPE_PARITY_EN
      checks++;
      if (y_par !== 1'b0) begin errors++; $display("FAIL arst_y_par: got %b want 0", y_par); end
`endif
      @(negedge clk);
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL arst_held: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
      end
      rst = 1'b0; scan = 1'b1; in_valid = 1'b1; out_ready = 1'b1; din = $urandom;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_first_accept: in_ready got %b want 1", in_ready); end
      step();
      in_valid = 1'b0;
      step();
      #1;
      checks++;
      if (out_valid !== 1'b1 || y_chan !== 2'd0 || y !== din[7:0]) begin
         errors++;
         $display("FAIL arst_cnt_cleared: got v=%b ch=%0d y=%h want v=1 ch=0 y=%h", out_valid, y_chan, y, din[7:0]);
      end
      step();
   endtask

   initial begin
      rst = 1'b1; din = '0; sel = '0; scan = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      din_b = '0; sel_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b1;
      test_reset();
      @(negedge clk);
      test_basic();
      test_scan_back_to_back();
      test_backpressure();
      test_random();
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) step();
      test_sel_range();
`ifdef WIDE_MUX_PIPE_PARITY_EN
      test_parity();
`endif
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
